// File: rtl/piso_word_serializer.sv
// Parallel-in / serial-out word serialiser: accepts an N-bit word on a valid/ready
// handshake and emits it LSB first, one bit per cycle with a shift-enable strobe.
module piso_word_serializer #(
  parameter int unsigned N   = 4,
  parameter int unsigned GAP = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic [N-1:0] load_data,
  output logic         ser_out,
  output logic         ser_en,
  output logic         busy,
  output logic         done
);

  localparam int unsigned BW       = $clog2(N);
  localparam int unsigned GW       = $clog2((GAP > 1) ? GAP : 2);
  localparam int unsigned GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  sreg_q, sreg_d;
  logic [BW-1:0] bitcnt_q, bitcnt_d;
  logic [GW-1:0] gapcnt_q, gapcnt_d;
  logic          ser_out_q, ser_out_d;
  logic          ser_en_q, ser_en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          load_ready_q, load_ready_d;

  logic accept_c;
  logic last_bit_c;
  logic gap_last_c;

  // load_ready_q gates acceptance so nothing is captured on the first edge after reset
  assign accept_c   = (state_q == ST_IDLE) && load_valid && load_ready_q;
  assign last_bit_c = (bitcnt_q == BW'(N - 1));
  assign gap_last_c = (gapcnt_q == GW'(GAP_LAST));

  assign load_ready = load_ready_q;
  assign ser_out    = ser_out_q;
  assign ser_en     = ser_en_q;
  assign busy       = busy_q;
  assign done       = done_q;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sreg_q       <= '0;
      bitcnt_q     <= '0;
      gapcnt_q     <= '0;
      ser_out_q    <= 1'b0;
      ser_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      load_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sreg_q       <= sreg_d;
      bitcnt_q     <= bitcnt_d;
      gapcnt_q     <= gapcnt_d;
      ser_out_q    <= ser_out_d;
      ser_en_q     <= ser_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      load_ready_q <= load_ready_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept_c) state_d = ST_SHIFT;
      ST_SHIFT: if (last_bit_c) state_d = (GAP > 0) ? ST_GAP : ST_IDLE;
      ST_GAP:   if (gap_last_c) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath update; outputs are precomputed from next-cycle values and registered
  always_comb begin
    sreg_d   = sreg_q;
    bitcnt_d = bitcnt_q;
    gapcnt_d = gapcnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          sreg_d   = load_data;
          bitcnt_d = '0;
        end
      end
      ST_SHIFT: begin
        sreg_d   = sreg_q >> 1;
        bitcnt_d = last_bit_c ? '0 : bitcnt_q + BW'(1);
        gapcnt_d = '0;
      end
      ST_GAP: begin
        gapcnt_d = gapcnt_q + GW'(1);
      end
      default: begin
        sreg_d   = '0;
        bitcnt_d = '0;
        gapcnt_d = '0;
      end
    endcase

    ser_en_d     = (state_d == ST_SHIFT);
    ser_out_d    = ser_en_d & sreg_d[0];
    done_d       = ser_en_d && (bitcnt_d == BW'(N - 1));
    busy_d       = (state_d != ST_IDLE);
    load_ready_d = (state_d == ST_IDLE);
  end

endmodule

// File: tb/tb_piso_word_serializer.sv
// Scoreboard bench for piso_word_serializer: an N=4/GAP=1 instance for the main
// directed cases and an N=8/GAP=0 instance for back-to-back streaming.
module tb_piso_word_serializer;

  logic clk;
  logic rst_n;

  logic       load_valid4, load_ready4, ser_out4, ser_en4, busy4, done4;
  logic [3:0] load_data4;
  logic       load_valid8, load_ready8, ser_out8, ser_en8, busy8, done8;
  logic [7:0] load_data8;

  piso_word_serializer #(.N(4), .GAP(1)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .load_valid(load_valid4), .load_ready(load_ready4), .load_data(load_data4),
    .ser_out(ser_out4), .ser_en(ser_en4), .busy(busy4), .done(done4)
  );

  piso_word_serializer #(.N(8), .GAP(0)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .load_valid(load_valid8), .load_ready(load_ready8), .load_data(load_data8),
    .ser_out(ser_out8), .ser_en(ser_en8), .busy(busy8), .done(done8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream 4-bit right-shift register fed by the N=4 instance
  logic [3:0] ds_q = 4'h0;
  always @(posedge clk) if (ser_en4) ds_q <= {ser_out4, ds_q[3:1]};

  // Expected entries: {done, bit}
  logic [1:0] q4[$];
  logic [1:0] q8[$];

  int n_chk  = 0;
  int n_fail = 0;
  int done8_cnt = 0;
  int en8_cnt = 0;
  longint first_t8 = -1;
  longint last_t8 = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_ready4(input string name);
    int n = 0;
    while (!load_ready4 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) check({name, "_timeout"}, 32'(load_ready4), 32'd1);
  endtask

  task automatic send4(input logic [3:0] w, input bit hold);
    load_data4  = w;
    load_valid4 = 1'b1;
    wait_ready4("send4");
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) q4.push_back({i == 3, w[i]});
    if (!hold) load_valid4 = 1'b0;
  endtask

  task automatic count_ready_low4(input string name, input int exp);
    int n = 0;
    while (!load_ready4 && n < 50) begin
      n++;
      @(posedge clk); #1;
    end
    check(name, 32'(n), 32'(exp));
  endtask

  task automatic drain4(input string name);
    int n = 0;
    while ((q4.size() != 0 || busy4) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_drain"}, 32'(q4.size()), 32'd0);
    wait_ready4(name);
  endtask

  initial begin
    rst_n       = 1'b0;
    load_valid4 = 1'b1;
    load_data4  = 4'hF;
    load_valid8 = 1'b0;
    load_data8  = 8'h00;

    fork
      forever begin
        @(negedge clk);
        if (ser_en4) begin
          if (q4.size() == 0) begin
            check("unexpected_bit4", 32'(ser_en4), 32'd0);
          end else begin
            logic [1:0] e;
            e = q4.pop_front();
            check("ser_out4", 32'(ser_out4), 32'(e[0]));
            check("done4", 32'(done4), 32'(e[1]));
          end
        end else if (done4) begin
          check("done4_without_en", 32'(done4), 32'd0);
        end
      end
      forever begin
        @(negedge clk);
        if (done8) done8_cnt++;
        if (ser_en8) begin
          en8_cnt++;
          if (first_t8 < 0) first_t8 = $time;
          last_t8 = $time;
          if (q8.size() == 0) begin
            check("unexpected_bit8", 32'(ser_en8), 32'd0);
          end else begin
            logic [1:0] e;
            e = q8.pop_front();
            check("ser_out8", 32'(ser_out8), 32'(e[0]));
            check("done8", 32'(done8), 32'(e[1]));
          end
        end
      end
    join_none

    // 1. Reset with load_valid high
    repeat (3) @(posedge clk);
    #1;
    check("rst_ser_en", 32'(ser_en4), 32'd0);
    check("rst_ready", 32'(load_ready4), 32'd0);
    check("rst_busy", 32'(busy4), 32'd0);
    check("rst_done", 32'(done4), 32'd0);
    check("rst_ser_out", 32'(ser_out4), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel_ready", 32'(load_ready4), 32'd1);
    check("rel_no_capture_en", 32'(ser_en4), 32'd0);
    check("rel_no_capture_busy", 32'(busy4), 32'd0);
    load_valid4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rel_idle_busy", 32'(busy4), 32'd0);

    // 2. Single word, downstream register reconstructs it
    send4(4'b1010, 1'b0);
    check("t2_busy", 32'(busy4), 32'd1);
    check("t2_ready_low", 32'(load_ready4), 32'd0);
    drain4("t2");
    check("t2_downstream_q", 32'(ds_q), 32'hA);

    // 3. Back-to-back with valid held high
    send4(4'b0011, 1'b1);
    load_data4 = 4'b1100;
    count_ready_low4("t3_ready_low_w0", 5);
    send4(4'b1100, 1'b0);
    count_ready_low4("t3_ready_low_w1", 5);
    drain4("t3");
    check("t3_downstream_q", 32'(ds_q), 32'hC);

    // 4. load_valid pulsed during SHIFT is ignored
    send4(4'b0001, 1'b0);
    load_data4  = 4'b1111;
    load_valid4 = 1'b1;
    check("t4_ready_in_shift", 32'(load_ready4), 32'd0);
    @(posedge clk); #1;
    load_valid4 = 1'b0;
    drain4("t4");
    repeat (4) @(posedge clk);
    #1;
    check("t4_no_extra_word", 32'(busy4), 32'd0);
    check("t4_downstream_q", 32'(ds_q), 32'h1);

    // 5. Reset mid-word drops the partial word immediately
    send4(4'b0110, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_ser_en_async", 32'(ser_en4), 32'd0);
    check("t5_busy_async", 32'(busy4), 32'd0);
    check("t5_bits_emitted", 32'(q4.size()), 32'd2);
    q4.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send4(4'b0110, 1'b0);
    drain4("t5");
    check("t5_downstream_q", 32'(ds_q), 32'h6);

    // 6. N=8, GAP=0, continuous valid
    load_data8  = 8'hA5;
    load_valid8 = 1'b1;
    begin
      int n = 0;
      while (!load_ready8 && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      check("t6_ready_initial", 32'(load_ready8), 32'd1);
      @(posedge clk); #1;
      for (int i = 0; i < 8; i++) q8.push_back({i == 7, load_data8[i]});
      load_data8 = 8'h3C;
      n = 0;
      while (!load_ready8 && n < 50) begin
        n++;
        @(posedge clk); #1;
      end
      check("t6_ready_low", 32'(n), 32'd8);
      @(posedge clk); #1;
      for (int i = 0; i < 8; i++) q8.push_back({i == 7, load_data8[i]});
      load_valid8 = 1'b0;
      n = 0;
      while ((q8.size() != 0 || busy8) && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      repeat (3) @(posedge clk);
      #1;
    end
    check("t6_drain", 32'(q8.size()), 32'd0);
    check("t6_done_pulses", 32'(done8_cnt), 32'd2);
    check("t6_bit_count", 32'(en8_cnt), 32'd16);
    check("t6_span_cycles", 32'((last_t8 - first_t8) / 10), 32'd16);
    check("final_q4_empty", 32'(q4.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
